// File: rtl/dmrf_ctrl_fsm_if.sv
// dmrf_ctrl_fsm_if: control bundle between the multicycle sequencer and the
// FullDMRFALU datapath. The sequencer is the initiating end (master): it takes
// the instruction fields and drives the datapath strobes.
interface dmrf_ctrl_fsm_if;
  // instruction side
  logic        start;
  logic [3:0]  opcode;
  logic [3:0]  funct;
  logic [15:0] imm;
  // datapath control strobes
  logic        MemWrite;
  logic        MemRead;
  logic        RegWrite;
  logic [1:0]  ALUOp;
  logic [3:0]  FuncCode;
  logic [15:0] SEin;
  logic        sel;
  // status
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    input  start, opcode, funct, imm,
    output MemWrite, MemRead, RegWrite, ALUOp, FuncCode, SEin, sel,
    output busy, done, err
  );

  modport slave (
    output start, opcode, funct, imm,
    input  MemWrite, MemRead, RegWrite, ALUOp, FuncCode, SEin, sel,
    input  busy, done, err
  );
endinterface

// File: rtl/dmrf_ctrl_fsm.sv
// dmrf_ctrl_fsm: multicycle control sequencer for the FullDMRFALU datapath.
// One instruction per start/done handshake, stepping DECODE -> EXEC -> (MEM) ->
// (WB) -> DONE. Every output is a register loaded from the next-state value, so
// the strobes line up exactly with the state they belong to (Moore).
// Optional feature: define DMRF_CTRL_ILLEGAL_TRAP_EN to make an illegal opcode
// raise a sticky err and lock the sequencer in IDLE until rst. Without it err
// is tied low and an illegal opcode finishes as a NOP.
module dmrf_ctrl_fsm (
  input  logic           clk,
  input  logic           rst,
  dmrf_ctrl_fsm_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [3:0] OP_R    = 4'd0;
  localparam logic [3:0] OP_LW   = 4'd1;
  localparam logic [3:0] OP_SW   = 4'd2;
  localparam logic [3:0] OP_ADDI = 4'd3;

  logic [2:0]  r_state;
  logic [2:0]  w_state_next;
  logic [3:0]  r_opcode;
  logic [3:0]  r_funct;
  logic [15:0] r_imm;
  logic        w_accept;
  logic        w_legal;
  logic        w_trap;

  logic        r_mem_write, w_mem_write_next;
  logic        r_mem_read,  w_mem_read_next;
  logic        r_reg_write, w_reg_write_next;
  logic [1:0]  r_alu_op,    w_alu_op_next;
  logic [3:0]  r_func_code, w_func_code_next;
  logic [15:0] r_se_in,     w_se_in_next;
  logic        r_sel,       w_sel_next;
  logic        r_busy,      w_busy_next;
  logic        r_done,      w_done_next;
  logic        w_hold;

`ifdef DMRF_CTRL_ILLEGAL_TRAP_EN
  logic r_err;
  logic w_err_next;
  assign w_trap = r_err;
`else
  assign w_trap = 1'b0;
`endif

  // Only opcodes 0..3 have a datapath meaning.
  assign w_legal  = (r_opcode == OP_R) || (r_opcode == OP_LW) ||
                    (r_opcode == OP_SW) || (r_opcode == OP_ADDI);
  // A new instruction is taken only between instructions and never while trapped.
  assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start && !w_trap;

  // Next-state selection: the path length depends only on the captured opcode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   w_state_next = w_accept ? S_DECODE : S_IDLE;
      S_DECODE: w_state_next = w_legal ? S_EXEC : S_DONE;
      S_EXEC:   w_state_next = ((r_opcode == OP_LW) || (r_opcode == OP_SW)) ? S_MEM : S_WB;
      S_MEM:    w_state_next = (r_opcode == OP_LW) ? S_WB : S_DONE;
      S_WB:     w_state_next = S_DONE;
      S_DONE:   w_state_next = w_accept ? S_DECODE : S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Output values for the state about to be entered. On an accept the next
  // state is DECODE, where everything is low, so r_opcode is always the right
  // opcode to decode here.
  always_comb begin
    w_hold           = w_legal && ((w_state_next == S_EXEC) || (w_state_next == S_MEM) ||
                                   (w_state_next == S_WB)   || (w_state_next == S_DONE));
    w_mem_write_next = (w_state_next == S_MEM) && (r_opcode == OP_SW);
    w_mem_read_next  = ((w_state_next == S_MEM) || (w_state_next == S_WB)) && (r_opcode == OP_LW);
    w_reg_write_next = (w_state_next == S_WB);
    w_sel_next       = (w_state_next == S_WB) && (r_opcode == OP_LW);
    w_alu_op_next    = (w_hold && (r_opcode == OP_R)) ? 2'd2 : 2'd0;
    w_func_code_next = (w_hold && (r_opcode == OP_R)) ? r_funct : 4'd0;
    w_se_in_next     = w_hold ? r_imm : 16'd0;
    w_busy_next      = (w_state_next == S_DECODE) || (w_state_next == S_EXEC) ||
                       (w_state_next == S_MEM)    || (w_state_next == S_WB);
    w_done_next      = (w_state_next == S_DONE);
  end

  // State register and instruction capture; fields are sampled only on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_opcode <= 4'd0;
      r_funct  <= 4'd0;
      r_imm    <= 16'd0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_opcode <= bus.opcode;
        r_funct  <= bus.funct;
        r_imm    <= bus.imm;
      end
    end
  end

  // Registered control outputs; reset drops any pending strobe immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_reg_write <= 1'b0;
      r_alu_op    <= 2'd0;
      r_func_code <= 4'd0;
      r_se_in     <= 16'd0;
      r_sel       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_mem_write <= w_mem_write_next;
      r_mem_read  <= w_mem_read_next;
      r_reg_write <= w_reg_write_next;
      r_alu_op    <= w_alu_op_next;
      r_func_code <= w_func_code_next;
      r_se_in     <= w_se_in_next;
      r_sel       <= w_sel_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
    end
  end

`ifdef DMRF_CTRL_ILLEGAL_TRAP_EN
  // Sticky trap flag, raised together with the DONE of an illegal opcode.
  always_comb begin
    w_err_next = r_err || ((w_state_next == S_DONE) && !w_legal);
  end

  // Trap flag register; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_err_next;
  end

  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.MemWrite = r_mem_write;
  assign bus.MemRead  = r_mem_read;
  assign bus.RegWrite = r_reg_write;
  assign bus.ALUOp    = r_alu_op;
  assign bus.FuncCode = r_func_code;
  assign bus.SEin     = r_se_in;
  assign bus.sel      = r_sel;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_dmrf_ctrl_fsm.sv
// tb_dmrf_ctrl_fsm: directed bench for dmrf_ctrl_fsm. A schedule model expands
// each accepted instruction into its per-cycle expected outputs from the
// latency table; a compare process checks every cycle, and literal checks pin
// the key cycles of each scenario.
module tb_dmrf_ctrl_fsm;

`ifdef DMRF_CTRL_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmrf_ctrl_fsm_if bus ();

  dmrf_ctrl_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Expected outputs for one cycle; set_err marks the cycle where err rises.
  typedef struct packed {
    logic        mw;
    logic        mr;
    logic        rw;
    logic [1:0]  aluop;
    logic [3:0]  func;
    logic [15:0] sein;
    logic        sel;
    logic        busy;
    logic        done;
    logic        set_err;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  logic err_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Expand one instruction into the outputs of each cycle from DECODE to DONE.
  function automatic void build(input logic [3:0] op, input logic [3:0] f, input logic [15:0] m);
    exp_t d, e, t;
    d = '0;
    d.busy = 1'b1;
    exp_q.push_back(d);
    if (op > 4'd3) begin
      t = '0;
      t.done = 1'b1;
      t.set_err = TRAP;
      exp_q.push_back(t);
      return;
    end
    e = d;
    e.aluop = (op == 4'd0) ? 2'd2 : 2'd0;
    e.func  = (op == 4'd0) ? f : 4'd0;
    e.sein  = m;
    exp_q.push_back(e);
    t = e;
    if (op == 4'd1) begin
      t.mr = 1'b1;
      exp_q.push_back(t);
      t.rw = 1'b1;
      t.sel = 1'b1;
      exp_q.push_back(t);
    end else if (op == 4'd2) begin
      t.mw = 1'b1;
      exp_q.push_back(t);
    end else begin
      t.rw = 1'b1;
      exp_q.push_back(t);
    end
    t = e;
    t.busy = 1'b0;
    t.done = 1'b1;
    exp_q.push_back(t);
  endfunction

  // Model: an empty schedule means the sequencer is idle or in DONE.
  initial begin
    cur = '0;
    err_m = 1'b0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        exp_q.delete();
        cur = '0;
        err_m = 1'b0;
      end else begin
        if (exp_q.size() == 0 && !err_m && bus.start === 1'b1)
          build(bus.opcode, bus.funct, bus.imm);
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else cur = '0;
        if (cur.set_err) err_m = 1'b1;
      end
    end
  end

  function automatic logic [31:0] dut_vec();
    return {3'b0, bus.MemWrite, bus.MemRead, bus.RegWrite, bus.ALUOp, bus.FuncCode,
            bus.SEin, bus.sel, bus.busy, bus.done, bus.err};
  endfunction

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("cycle", dut_vec(), {3'b0, cur[28:1], err_m});
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one start pulse; returns at the negedge of the DECODE cycle (k+1).
  task automatic issue(input logic [3:0] op, input logic [3:0] f, input logic [15:0] m);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.opcode = op;
    bus.funct  = f;
    bus.imm    = m;
    @(negedge clk);
    bus.start = 1'b0;
    $display("txn op=%0h funct=%0h imm=%04h", op, f, m);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.opcode = 4'd0;
    bus.funct  = 4'd0;
    bus.imm    = 16'd0;
    rst = 1'b1;
    cyc(3);
    chk("reset_outputs", dut_vec(), 32'd0);
    rst = 1'b0;
    cyc(2);

    // R-type, funct 2
    issue(4'd0, 4'b0010, 16'h1234);
    chk("r_decode_busy", {31'd0, bus.busy}, 32'd1);
    cyc(1);
    chk("r_aluop", {30'd0, bus.ALUOp}, 32'd2);
    chk("r_func", {28'd0, bus.FuncCode}, 32'd2);
    chk("r_rw_k2", {31'd0, bus.RegWrite}, 32'd0);
    cyc(1);
    chk("r_regwrite", {31'd0, bus.RegWrite}, 32'd1);
    chk("r_sel", {31'd0, bus.sel}, 32'd0);
    cyc(1);
    chk("r_done", {30'd0, bus.done, bus.RegWrite}, 32'b10);
    cyc(1);
    chk("r_after", {30'd0, bus.done, bus.busy}, 32'd0);

    // LW, imm 0x0014
    issue(4'd1, 4'd0, 16'h0014);
    cyc(1);
    chk("lw_sein", {16'd0, bus.SEin}, 32'h14);
    cyc(1);
    chk("lw_mem", {30'd0, bus.MemRead, bus.RegWrite}, 32'b10);
    cyc(1);
    chk("lw_wb", {29'd0, bus.MemRead, bus.RegWrite, bus.sel}, 32'b111);
    cyc(1);
    chk("lw_done", {30'd0, bus.done, bus.MemRead}, 32'b10);

    // SW, imm 0x000A
    issue(4'd2, 4'd0, 16'h000A);
    cyc(2);
    chk("sw_mem", {30'd0, bus.MemWrite, bus.RegWrite}, 32'b10);
    cyc(1);
    chk("sw_done", {29'd0, bus.done, bus.MemWrite, bus.RegWrite}, 32'b100);
    cyc(1);

    // Back-to-back ADDI then SW with start held high
    @(negedge clk);
    bus.start  = 1'b1;
    bus.opcode = 4'd3;
    bus.funct  = 4'd0;
    bus.imm    = 16'h0005;
    @(negedge clk);
    bus.opcode = 4'd2;
    bus.imm    = 16'h00A0;
    $display("txn op=3 imm=0005 then op=2 imm=00a0 (start held)");
    cyc(3);
    chk("b2b_first_done", {31'd0, bus.done}, 32'd1);
    cyc(1);
    chk("b2b_second_decode", {30'd0, bus.busy, bus.done}, 32'b10);
    bus.start = 1'b0;
    cyc(1);
    bus.start  = 1'b1;
    bus.opcode = 4'd1;
    bus.imm    = 16'h0BAD;
    chk("b2b_sein", {16'd0, bus.SEin}, 32'hA0);
    cyc(1);
    bus.start = 1'b0;
    chk("b2b_mem", {31'd0, bus.MemWrite}, 32'd1);
    cyc(1);
    chk("b2b_done", {31'd0, bus.done}, 32'd1);
    cyc(1);
    chk("b2b_pulse_ignored", {31'd0, bus.busy}, 32'd0);

    // Reset during MEM of an SW
    issue(4'd2, 4'd0, 16'h0033);
    cyc(2);
    chk("rst_mem_before", {31'd0, bus.MemWrite}, 32'd1);
    #2 rst = 1'b1;
    #1 chk("rst_async_clear", dut_vec(), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cyc(3);
    chk("rst_no_done", {30'd0, bus.done, bus.busy}, 32'd0);

    // Illegal opcode 4'hF
    issue(4'hF, 4'd0, 16'h0077);
    chk("ill_decode", {31'd0, bus.busy}, 32'd1);
    cyc(1);
    chk("ill_done", {31'd0, bus.done}, 32'd1);
    chk("ill_err", {31'd0, bus.err}, {31'd0, TRAP});
    chk("ill_strobes", {bus.MemWrite, bus.MemRead, bus.RegWrite, bus.ALUOp, bus.SEin}, 32'd0);
    cyc(1);

    // A later start: ignored when trapped, executed otherwise
    issue(4'd0, 4'd1, 16'h0001);
    chk("post_ill_start", {30'd0, bus.busy, bus.err}, TRAP ? 32'b01 : 32'b10);
    cyc(6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
